// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit pipelined MIPS CPU.
// Holds the pipeline register layouts and the branch-resolution helper.
package cpu16_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 2;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Branch field is a one-hot-ish mask: bit 0 selects BEQ, bit 1 selects BNE.
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  // Bit positions inside the MainControl word produced in ID.
  localparam int CTRL_REGDST    = 0;
  localparam int CTRL_ALUSRC    = 1;
  localparam int CTRL_MEMTOREG  = 2;
  localparam int CTRL_REGWRITE  = 3;
  localparam int CTRL_MEMREAD   = 4;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_BRANCH_EQ = 6;
  localparam int CTRL_BRANCH_NE = 7;
  localparam int CTRL_W         = 8;

  typedef struct packed {
    word_t      ir;
    word_t      alu_out;
    logic       zero;
    word_t      store_data;
    reg_idx_t   wr;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] branch;
    word_t      target;
  } exmem_t;

  typedef struct packed {
    word_t    ir;
    word_t    data;
    reg_idx_t wr;
    logic     regwrite;
  } memwb_t;

  function automatic logic branch_taken(input logic [1:0] branch, input logic zero);
    return (((branch & BR_EQ) != BR_NONE) &  zero) |
           (((branch & BR_NE) != BR_NONE) & ~zero);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the execute stage and mem_wb_stage.
// master = EX side (drives ex_*), slave = mem_wb_stage.
interface mem_wb_stage_if;
  import cpu16_pkg::*;

  word_t      ex_ir;
  word_t      ex_alu_out;
  logic       ex_zero;
  word_t      ex_store_data;
  reg_idx_t   ex_wr;
  logic       ex_regwrite;
  logic       ex_memwrite;
  logic       ex_memtoreg;
  logic [1:0] ex_branch;
  word_t      ex_target;

  word_t      exmem_ir;
  word_t      memwb_ir;
  logic       pcsrc;
  word_t      branch_target;
  logic       flush;
  reg_idx_t   wb_wr;
  word_t      wb_wd;
  logic       wb_regwrite;
  logic       fwd_mem_en;
  logic       fwd_wb_en;
  reg_idx_t   fwd_mem_wr;
  reg_idx_t   fwd_wb_wr;
  word_t      fwd_mem_val;
  word_t      fwd_wb_val;

  modport master (
    output ex_ir, ex_alu_out, ex_zero, ex_store_data, ex_wr,
           ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch, ex_target,
    input  exmem_ir, memwb_ir, pcsrc, branch_target, flush,
           wb_wr, wb_wd, wb_regwrite,
           fwd_mem_en, fwd_wb_en, fwd_mem_wr, fwd_wb_wr, fwd_mem_val, fwd_wb_val
  );

  modport slave (
    input  ex_ir, ex_alu_out, ex_zero, ex_store_data, ex_wr,
           ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch, ex_target,
    output exmem_ir, memwb_ir, pcsrc, branch_target, flush,
           wb_wr, wb_wd, wb_regwrite,
           fwd_mem_en, fwd_wb_en, fwd_mem_wr, fwd_wb_wr, fwd_mem_val, fwd_wb_val
  );

endinterface

// File: rtl/data_mem.sv
// Data memory: DMEM_DEPTH x 16, negedge write with enable, asynchronous read.
// Preload hook: a bench may fill u_dmem.mem[] from its own initial block.
module data_mem
  import cpu16_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] addr,
  input  word_t              wdata,
  output word_t              rdata
);

  word_t mem [DMEM_DEPTH];

  // NOTE: storage arrays get no reset; clearing them would turn the RAM into
  // thousands of flops. Sequential state uses <= so all edge updates see old values.
  always_ff @(negedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB stages: EX/MEM register, data memory, branch resolution, MEM/WB register.
// Optional forwarding outputs are enabled with `define MEM_WB_FWD_EN.
module mem_wb_stage
  import cpu16_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  exmem_t             exmem;
  exmem_t             exmem_nxt;
  memwb_t             memwb;
  logic               pcsrc;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  word_t              dmem_rdata;

  assign pcsrc = branch_taken(exmem.branch, exmem.zero);

  // NOTE: every always_comb output gets a full default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    exmem_nxt = '{ir:         bus.ex_ir,
                  alu_out:    bus.ex_alu_out,
                  zero:       bus.ex_zero,
                  store_data: bus.ex_store_data,
                  wr:         bus.ex_wr,
                  regwrite:   bus.ex_regwrite,
                  memwrite:   bus.ex_memwrite,
                  memtoreg:   bus.ex_memtoreg,
                  branch:     bus.ex_branch,
                  target:     bus.ex_target};
    // A taken branch kills the instruction fetched behind it.
    if (pcsrc) begin
      exmem_nxt.ir       = '0;
      exmem_nxt.regwrite = 1'b0;
      exmem_nxt.memwrite = 1'b0;
      exmem_nxt.branch   = BR_NONE;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) exmem <= '0;
    else     exmem <= exmem_nxt;
  end

  // Bit 0 drops (halfword alignment); bits above DMEM_AW wrap.
  assign dmem_addr = exmem.alu_out[DMEM_AW:1];
  assign dmem_we   = exmem.memwrite & ~rst;

  data_mem #(
    .DMEM_DEPTH (DMEM_DEPTH),
    .DMEM_AW    (DMEM_AW)
  ) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (dmem_addr),
    .wdata (exmem.store_data),
    .rdata (dmem_rdata)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      memwb <= '0;
    end else begin
      memwb.ir       <= exmem.ir;
      memwb.data     <= exmem.memtoreg ? dmem_rdata : exmem.alu_out;
      memwb.wr       <= exmem.wr;
      memwb.regwrite <= exmem.regwrite;
    end
  end

  assign bus.exmem_ir      = exmem.ir;
  assign bus.memwb_ir      = memwb.ir;
  assign bus.pcsrc         = pcsrc;
  assign bus.flush         = pcsrc;
  assign bus.branch_target = exmem.target;
  assign bus.wb_wr         = memwb.wr;
  assign bus.wb_wd         = memwb.data;
  // $0 is hardwired, so a write to it is dropped here.
  assign bus.wb_regwrite   = memwb.regwrite & (memwb.wr != '0);

`ifdef MEM_WB_FWD_EN
  assign bus.fwd_mem_en  = exmem.regwrite & ~exmem.memtoreg & (exmem.wr != '0);
  assign bus.fwd_mem_wr  = exmem.wr;
  assign bus.fwd_mem_val = exmem.alu_out;
  assign bus.fwd_wb_en   = bus.wb_regwrite;
  assign bus.fwd_wb_wr   = bus.wb_wr;
  assign bus.fwd_wb_val  = bus.wb_wd;
`else
  assign bus.fwd_mem_en  = 1'b0;
  assign bus.fwd_mem_wr  = '0;
  assign bus.fwd_mem_val = '0;
  assign bus.fwd_wb_en   = 1'b0;
  assign bus.fwd_wb_wr   = '0;
  assign bus.fwd_wb_val  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expectations,
// a posedge monitor pops and compares them against the negedge-updated outputs.
module tb_mem_wb_stage;
  import cpu16_pkg::*;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  always @(negedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  typedef struct {
    word_t      ir;
    word_t      alu;
    logic       zero;
    word_t      sd;
    reg_idx_t   wr;
    logic       rw;
    logic       mw;
    logic       m2r;
    logic [1:0] br;
    word_t      tgt;
    logic       e_rw;
    word_t      e_wd;
    logic       e_pc;
    logic       e_fm;
  } vec_t;

  typedef struct { int due; logic pc; word_t tgt; } br_exp_t;
  typedef struct { int due; logic en; reg_idx_t wr; word_t val; } fm_exp_t;
  typedef struct { int due; logic rw; reg_idx_t wr; word_t wd; logic chk_wd; } wb_exp_t;

  br_exp_t br_q[$];
  fm_exp_t fm_q[$];
  wb_exp_t wb_q[$];
  br_exp_t be;
  fm_exp_t fe;
  wb_exp_t we;
  vec_t    vecs[$];
  vec_t    nop;

  task automatic drive(input vec_t v);
    bus.ex_ir         = v.ir;
    bus.ex_alu_out    = v.alu;
    bus.ex_zero       = v.zero;
    bus.ex_store_data = v.sd;
    bus.ex_wr         = v.wr;
    bus.ex_regwrite   = v.rw;
    bus.ex_memwrite   = v.mw;
    bus.ex_memtoreg   = v.m2r;
    bus.ex_branch     = v.br;
    bus.ex_target     = v.tgt;
  endtask

  // Present v before the next negedge N; branch/MEM results due after N, WB after N+1.
  task automatic issue(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    br_q.push_back('{edge_cnt + 1, v.e_pc, v.tgt});
    fm_q.push_back('{edge_cnt + 1, v.e_fm, v.wr, v.alu});
    wb_q.push_back('{edge_cnt + 2, v.e_rw, v.wr, v.e_wd,
                     v.e_rw | ((v.alu == 16'h0) & ~v.m2r)});
  endtask

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      check("flush_eq_pcsrc", 16'(bus.flush), 16'(bus.pcsrc));
      while (br_q.size() > 0 && br_q[0].due <= edge_cnt) begin
        be = br_q.pop_front();
        check("pcsrc", 16'(bus.pcsrc), 16'(be.pc));
        if (be.pc) check("branch_target", bus.branch_target, be.tgt);
      end
      while (fm_q.size() > 0 && fm_q[0].due <= edge_cnt) begin
        fe = fm_q.pop_front();
`ifdef MEM_WB_FWD_EN
        check("fwd_mem_en", 16'(bus.fwd_mem_en), 16'(fe.en));
        if (fe.en) begin
          check("fwd_mem_wr", 16'(bus.fwd_mem_wr), 16'(fe.wr));
          check("fwd_mem_val", bus.fwd_mem_val, fe.val);
        end
`else
        check("fwd_mem_off", {14'(bus.fwd_mem_val[13:0]), bus.fwd_mem_wr} | 16'(bus.fwd_mem_en)
              | bus.fwd_mem_val, 16'h0);
`endif
      end
      while (wb_q.size() > 0 && wb_q[0].due <= edge_cnt) begin
        we = wb_q.pop_front();
        check("wb_regwrite", 16'(bus.wb_regwrite), 16'(we.rw));
        if (we.rw)     check("wb_wr", 16'(bus.wb_wr), 16'(we.wr));
        if (we.chk_wd) check("wb_wd", bus.wb_wd, we.wd);
`ifdef MEM_WB_FWD_EN
        check("fwd_wb_en", 16'(bus.fwd_wb_en), 16'(we.rw));
        if (we.rw) begin
          check("fwd_wb_wr", 16'(bus.fwd_wb_wr), 16'(we.wr));
          check("fwd_wb_val", bus.fwd_wb_val, we.wd);
        end
`else
        check("fwd_wb_off", bus.fwd_wb_val | 16'(bus.fwd_wb_wr) | 16'(bus.fwd_wb_en), 16'h0);
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_regwrite"}, 16'(bus.wb_regwrite), 16'h0);
    check({tag, "_wb_wd"},       bus.wb_wd,             16'h0);
    check({tag, "_pcsrc"},       16'(bus.pcsrc),        16'h0);
    check({tag, "_flush"},       16'(bus.flush),        16'h0);
    check({tag, "_fwd_en"},      16'({bus.fwd_mem_en, bus.fwd_wb_en}), 16'h0);
    check({tag, "_fwd_val"},     bus.fwd_mem_val | bus.fwd_wb_val, 16'h0);
  endtask

  initial begin
    //        ir        alu       z     sd        wr    rw    mw    m2r   br       tgt       e_rw  e_wd      e_pc  e_fm
    nop = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs.push_back(nop);
    vecs.push_back(nop);
    vecs.push_back('{16'hB1A6, 16'd6,     1'b0, 16'h00A5, 2'd0, 1'b0, 1'b1, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // SW A5 -> 6
    vecs.push_back(nop);
    vecs.push_back('{16'h8206, 16'd6,     1'b0, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b1, BR_NONE, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0}); // LW 6
    vecs.push_back('{16'hA108, 16'd8,     1'b0, 16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // SW 1234 -> 8
    vecs.push_back('{16'h8108, 16'd8,     1'b0, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b1, BR_NONE, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0}); // LW 8
    vecs.push_back('{16'hC020, 16'h0000,  1'b1, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, BR_EQ,   16'h0020, 1'b0, 16'h0000, 1'b1, 1'b0}); // BEQ taken
    vecs.push_back('{16'h0164, 16'h0077,  1'b0, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // ADD squashed
    vecs.push_back(nop);
    vecs.push_back('{16'hD040, 16'h0000,  1'b1, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, BR_NE,   16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0}); // BNE not taken
    vecs.push_back('{16'h0154, 16'h0055,  1'b0, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b1, 16'h0055, 1'b0, 1'b1}); // ADD survives
    vecs.push_back('{16'hA202, 16'h0202,  1'b0, 16'hBEEF, 2'd0, 1'b0, 1'b1, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // SW wraps
    vecs.push_back(nop);
    vecs.push_back('{16'h8302, 16'h0002,  1'b0, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b1, BR_NONE, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0}); // LW 2
    vecs.push_back('{16'h0090, 16'h0099,  1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // ADD to $0
    vecs.push_back('{16'h0316, 16'd22,    1'b0, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b1, 16'd22,   1'b0, 1'b1}); // ADD 22 -> $3
    vecs.push_back('{16'hD100, 16'h0000,  1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, BR_NE,   16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0}); // BNE taken
    vecs.push_back('{16'h0288, 16'h0088,  1'b0, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, BR_NONE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}); // ADD squashed
    vecs.push_back(nop);
    vecs.push_back('{16'h8206, 16'd6,     1'b0, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b1, BR_NONE, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0}); // LW 6 for reset test
    vecs.push_back(nop);

    rst = 1'b1;
    drive(nop);
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);

    // The final LW reaches MEM/WB at this edge; reset while it sits there.
    @(negedge clk);
    #2;
    check("pre_rst_wb_regwrite", 16'(bus.wb_regwrite), 16'h1);
    check("pre_rst_wb_wd",       bus.wb_wd,             16'h00A5);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    br_q.delete();
    fm_q.delete();
    wb_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) issue(nop);

    for (int n = 0; n < 10 && (wb_q.size() + br_q.size() + fm_q.size()) > 0; n++)
      @(posedge clk);
    #1;
    if ((wb_q.size() + br_q.size() + fm_q.size()) != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", wb_q.size() + br_q.size() + fm_q.size());
    end
    check_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Downstream neighbour of the execute stage in the 16-bit pipelined MIPS CPU.
- Holds the EX/MEM pipeline register, the data memory (LW/SW), branch resolution (BEQ/BNE) and the MEM/WB register.
- Drives the register-file write port (wr/wd/regwrite) and the PC-redirect/flush signals back to IF/ID.

Parameters:
- DMEM_DEPTH, 256, data memory size in 16-bit words.
- DMEM_AW, 8, word-address width; must satisfy DMEM_DEPTH = 2**DMEM_AW.

Ports:
- clk  in  1  pipeline clock; all registers update on negedge, matching the CPU pipeline.
- rst  in  1  reset, asynchronous, active-high.
- ex_ir  in  16  instruction in EX, carried for monitoring.
- ex_alu_out  in  16  ALU result; this is the byte address for LW/SW.
- ex_zero  in  1  ALU zero flag.
- ex_store_data  in  16  RD2 forwarded for SW.
- ex_wr  in  2  destination register after the RegDst mux.
- ex_regwrite, ex_memwrite, ex_memtoreg  in  1 each  control bits.
- ex_branch  in  2  [0]=BEQ, [1]=BNE.
- ex_target  in  16  branch target PC.
- exmem_ir, memwb_ir  out  16  monitoring copies of the instruction.
- pcsrc  out  1  take branch.
- branch_target  out  16  redirect PC.
- flush  out  1  squash IF/ID and ID/EX; equals pcsrc.
- wb_wr  out  2  register-file write index.
- wb_wd  out  16  register-file write data.
- wb_regwrite  out  1  register-file write enable.
- fwd_mem_en, fwd_wb_en  out  1; fwd_mem_wr, fwd_wb_wr  out  2; fwd_mem_val, fwd_wb_val  out  16.

Behaviour:
- Reset:
  - Async on rst rise: every EX/MEM and MEM/WB field clears to 0, so both stages hold a nop.
  - All outputs read 0 while rst is high: pcsrc=0, flush=0, wb_regwrite=0, and all fwd_* = 0.
  - Data memory contents are not cleared.
  - If rst asserts during a cycle with a pending store, that store is not written.
- EX/MEM capture (negedge): latch every ex_* input.
  - If pcsrc=1 at that edge, latch a bubble instead: regwrite, memwrite and branch forced to 0, ir=0.
  - This kills the instruction behind the taken branch.
- Branch resolution, combinational from the EX/MEM register:
  - pcsrc = (branch[0] & zero) | (branch[1] & ~zero).
  - branch_target = exmem target.
  - pcsrc is high for exactly one cycle per taken branch.
- Data memory address: word = exmem alu_out[DMEM_AW:1].
  - Bit 0 is ignored (misaligned addresses are silently aligned down).
  - Upper bits are ignored (addresses wrap modulo DMEM_DEPTH).
- Store: written at the negedge that ends the store's MEM cycle, when exmem memwrite=1.
- Load: asynchronous read. A load entering MEM on that same edge reads the newly stored value (store-to-load through memory, 0 extra cycles).
- MEM/WB capture (negedge):
  - data = memtoreg ? dmem_rdata : alu_out.
  - wr, regwrite and ir pass through.
- WB outputs come directly from the MEM/WB register.
  - wb_regwrite is forced to 0 when wb_wr == 0, since $0 is hardwired.
- Latency: values presented on ex_* before negedge N appear on wb_* after negedge N+1, i.e. 2 edges.
- Simultaneous store and taken branch are impossible: a branch carries memwrite=0.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- Defined:
  - fwd_mem_en = exmem regwrite & ~memtoreg & (wr != 0); fwd_mem_wr/fwd_mem_val = exmem wr/alu_out.
  - fwd_wb_en/wr/val mirror wb_regwrite/wb_wr/wb_wd.
  - These feed a forwarding unit in EX.
- Undefined:
  - All fwd_* ports are still present, tied to 0.
  - No forwarding logic is synthesised, so programs must keep nops between dependent instructions.

Decomposition:
- Shared package cpu16_pkg:
  - WORD_W=16, REG_IDX_W=2.
  - BR_NONE=2'b00, BR_EQ=2'b01, BR_NE=2'b10.
  - Control-bit field positions of the MainControl word.
- One sub-module, data_mem: DMEM_DEPTH x 16, negedge write with enable, asynchronous read.
  - Has an initial-block preload hook for benches.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst while an LW sits in MEM/WB.
  - Response: wb_regwrite=0, wb_wd=0, pcsrc=0 immediately. After release with nops in, outputs stay 0.
- SW then LW, separated by a nop:
  - Stimulus: SW data 16'h00A5 to address 16'd6; LW from address 6 with wr=2.
  - Response: wb_wd=16'h00A5, wb_wr=2'b10, wb_regwrite=1, two edges after the LW is presented.
- Back-to-back SW/LW:
  - Stimulus: SW 16'h1234 to address 8, immediately followed by LW from address 8.
  - Response: wb_wd=16'h1234 (no stale read).
- BEQ and BNE resolution:
  - Stimulus: BEQ with zero=1, target 16'h0020.
  - Response: pcsrc=flush=1 for one cycle, branch_target=16'h0020. The following ADD (wr=1) captured into EX/MEM is squashed, so wb_regwrite stays 0 for it.
  - Stimulus: BNE with zero=1.
  - Response: pcsrc=0.
- Address wrap and writes to $0:
  - Stimulus: SW 16'hBEEF to address 16'h0202.
  - Response: a later LW from address 16'h0002 returns 16'hBEEF.
  - Stimulus: ADD with wr=0.
  - Response: wb_regwrite=0.
- MEM_WB_FWD_EN defined vs undefined:
  - Stimulus: ADD with alu_out=22, wr=3.
  - Response when defined: fwd_mem_en=1, fwd_mem_val=22 for one cycle, then fwd_wb_en=1 the next cycle.
  - Response when undefined: all fwd_* stay 0.
